// File: rtl/mig_ui_if.sv
// MIG 7-series user-interface (app_*) bundle between a DDR3 initiator and its responder.
interface mig_ui_if #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned DATA_WIDTH = 128
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [ADDR_WIDTH-1:0] app_addr;
    logic                  app_rdy;
    logic                  app_wdf_wren;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic                  app_wdf_end;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mig_ui_responder.sv
// DDR3-less stand-in for the MIG user interface: command and write-data FIFOs,
// in-order retirement into a block RAM, fixed-latency in-order read return.
module mig_ui_responder #(
    parameter int unsigned ADDR_WIDTH       = 28,
    parameter int unsigned DATA_WIDTH       = 128,
    parameter int unsigned MEM_DEPTH_LOG2   = 10,
    parameter int unsigned RD_LATENCY       = 4,
    parameter int unsigned CALIB_CYCLES     = 64,
    parameter int unsigned RDY_STALL_PERIOD = 0
) (
    input  logic    clk,
    input  logic    reset_n,
    output logic    init_calib_complete,
    mig_ui_if.slave ui,
    output logic    err_cmd,
    output logic    err_wdf
);
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned MEM_DEPTH  = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned CALIB_W    = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES + 1) : 1;
    localparam int unsigned STALL_W    = (RDY_STALL_PERIOD > 2) ? $clog2(RDY_STALL_PERIOD) : 1;
    localparam logic [2:0]  CMD_WRITE  = 3'b000;
    localparam logic [2:0]  CMD_READ   = 3'b001;

    typedef struct packed {
        logic [2:0]                op;
        logic [MEM_DEPTH_LOG2-1:0] idx;
    } cmd_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [MASK_WIDTH-1:0] mask;
    } wdf_t;

    logic                  calib_q;
    logic [CALIB_W-1:0]    cal_cnt_q;
    logic [STALL_W-1:0]    stall_cnt_q;
    logic                  stall_c;

    cmd_t                  cmd_ram_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      cmd_wptr_q, cmd_rptr_q;
    logic [CNT_W-1:0]      cmd_cnt_q, cmd_cnt_d;
    logic                  cmd_full_q, cmd_empty_q;
    logic                  cmd_push, cmd_pop;
    cmd_t                  cmd_head;

    wdf_t                  wdf_ram_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wdf_wptr_q, wdf_rptr_q;
    logic [CNT_W-1:0]      wdf_cnt_q, wdf_cnt_d;
    logic                  wdf_full_q, wdf_empty_q;
    logic                  wdf_push, wdf_pop;
    wdf_t                  wdf_head;

    logic                  rd_issue, wr_do, ill_do;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [RD_LATENCY-1:0] rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_dat_q [RD_LATENCY];
    logic                  err_cmd_q, err_wdf_q;
    logic                  app_rdy_c, app_wdf_rdy_c;

    // Only the word-index bits of the address matter; the rest alias.
    logic [ADDR_WIDTH-1:0] unused_addr;
    assign unused_addr = ui.app_addr;

    // Handshake readiness from registered flags only (no same-cycle pass-through).
    assign stall_c       = (RDY_STALL_PERIOD > 1) && (stall_cnt_q == '0);
    assign app_rdy_c     = calib_q & ~cmd_full_q & ~stall_c;
    assign app_wdf_rdy_c = calib_q & ~wdf_full_q;
    assign cmd_push      = ui.app_en & app_rdy_c;
    assign wdf_push      = ui.app_wdf_wren & app_wdf_rdy_c;
    assign cmd_head      = cmd_ram_q[cmd_rptr_q];
    assign wdf_head      = wdf_ram_q[wdf_rptr_q];
    assign cmd_pop       = rd_issue | wr_do | ill_do;
    assign wdf_pop       = wr_do;
    assign cmd_cnt_d     = cmd_cnt_q + CNT_W'(cmd_push) - CNT_W'(cmd_pop);
    assign wdf_cnt_d     = wdf_cnt_q + CNT_W'(wdf_push) - CNT_W'(wdf_pop);

    // Head decode: retire at most one command per cycle; a write waits for its data.
    always_comb begin
        rd_issue = 1'b0;
        wr_do    = 1'b0;
        ill_do   = 1'b0;
        if (!cmd_empty_q) begin
            case (cmd_head.op)
                CMD_WRITE: wr_do    = ~wdf_empty_q;
                CMD_READ:  rd_issue = 1'b1;
                default:   ill_do   = 1'b1;
            endcase
        end
    end

    // Calibration delay and free-running ready-stall counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cal_cnt_q   <= '0;
            calib_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (!calib_q) begin
                cal_cnt_q <= cal_cnt_q + CALIB_W'(1);
                calib_q   <= (32'(cal_cnt_q) + 32'd1) >= CALIB_CYCLES;
            end
            if (RDY_STALL_PERIOD > 1) begin
                stall_cnt_q <= (32'(stall_cnt_q) == RDY_STALL_PERIOD - 1) ? '0
                                                                          : stall_cnt_q + STALL_W'(1);
            end
        end
    end

    // FIFO pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wptr_q  <= '0;
            cmd_rptr_q  <= '0;
            cmd_cnt_q   <= '0;
            cmd_full_q  <= 1'b0;
            cmd_empty_q <= 1'b1;
            wdf_wptr_q  <= '0;
            wdf_rptr_q  <= '0;
            wdf_cnt_q   <= '0;
            wdf_full_q  <= 1'b0;
            wdf_empty_q <= 1'b1;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + PTR_W'(1);
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + PTR_W'(1);
            if (wdf_push) wdf_wptr_q <= wdf_wptr_q + PTR_W'(1);
            if (wdf_pop)  wdf_rptr_q <= wdf_rptr_q + PTR_W'(1);
            cmd_cnt_q   <= cmd_cnt_d;
            cmd_full_q  <= (cmd_cnt_d == CNT_W'(FIFO_DEPTH));
            cmd_empty_q <= (cmd_cnt_d == '0);
            wdf_cnt_q   <= wdf_cnt_d;
            wdf_full_q  <= (wdf_cnt_d == CNT_W'(FIFO_DEPTH));
            wdf_empty_q <= (wdf_cnt_d == '0);
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_ram_q[cmd_wptr_q] <= '{op: ui.app_cmd, idx: ui.app_addr[MEM_DEPTH_LOG2+2:3]};
        end
        if (wdf_push) begin
            wdf_ram_q[wdf_wptr_q] <= '{data: ui.app_wdf_data, mask: ui.app_wdf_mask};
        end
    end

    // Byte-masked memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_do) begin
            for (int b = 0; b < int'(MASK_WIDTH); b++) begin
                if (!wdf_head.mask[b]) mem_q[cmd_head.idx][8*b +: 8] <= wdf_head.data[8*b +: 8];
            end
        end
    end

    // Read pipe: memory read on issue, then shift to the RD_LATENCY-th stage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_q <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) rd_dat_q[i] <= '0;
        end else begin
            rd_vld_q[0] <= rd_issue;
            rd_dat_q[0] <= rd_issue ? mem_q[cmd_head.idx] : '0;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_dat_q[i] <= rd_dat_q[i-1];
            end
        end
    end

    // Sticky protocol-error flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_cmd_q <= 1'b0;
            err_wdf_q <= 1'b0;
        end else begin
            err_cmd_q <= err_cmd_q | ill_do;
            err_wdf_q <= err_wdf_q | (wdf_push & ~ui.app_wdf_end);
        end
    end

    assign init_calib_complete  = calib_q;
    assign ui.app_rdy           = app_rdy_c;
    assign ui.app_wdf_rdy       = app_wdf_rdy_c;
    assign ui.app_rd_data       = rd_dat_q[RD_LATENCY-1];
    assign ui.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
    assign ui.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];
    assign err_cmd              = err_cmd_q;
    assign err_wdf              = err_wdf_q;
endmodule

// File: tb/tb_mig_ui_responder.sv
// Randomized and directed bench for mig_ui_responder against an untimed queue model.
`timescale 1ns/1ps
module tb_mig_ui_responder;
    localparam int unsigned AW    = 28;
    localparam int unsigned DW    = 128;
    localparam int unsigned MW    = 16;
    localparam int unsigned DEPTH = 1024;
    localparam logic [2:0]  WR    = 3'b000;
    localparam logic [2:0]  RD    = 3'b001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic calib_a, err_cmd_a, err_wdf_a, calib_b, err_cmd_b, err_wdf_b;

    mig_ui_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ui_a ();
    mig_ui_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ui_b ();

    mig_ui_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10), .RD_LATENCY(4),
                       .CALIB_CYCLES(64), .RDY_STALL_PERIOD(0)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .init_calib_complete(calib_a), .ui(ui_a),
        .err_cmd(err_cmd_a), .err_wdf(err_wdf_a));

    mig_ui_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(10), .RD_LATENCY(4),
                       .CALIB_CYCLES(64), .RDY_STALL_PERIOD(3)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .init_calib_complete(calib_b), .ui(ui_b),
        .err_cmd(err_cmd_b), .err_wdf(err_wdf_b));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cycles since reset release (equals the DUT's calibration count)
    int cyc_a = 0, cyc_b = 0;
    always @(posedge clk) cyc_a <= rst_a_n ? cyc_a + 1 : 0;
    always @(posedge clk) cyc_b <= rst_b_n ? cyc_b + 1 : 0;

    // ---------------- reference model: untimed, in-order ----------------
    typedef struct { logic [2:0] op; int idx; } mcmd_t;
    typedef struct { logic [DW-1:0] d; logic [MW-1:0] m; } mdat_t;
    mcmd_t         mq[$];
    mdat_t         dq[$];
    logic [DW-1:0] mmem [DEPTH];
    bit            mknown [DEPTH];
    logic [DW-1:0] expq[$];
    bit            expk[$];
    logic [DW-1:0] expb[$];

    function automatic void model_retire();
        while (mq.size() > 0) begin
            if (mq[0].op == WR) begin
                if (dq.size() == 0) break;
                for (int b = 0; b < int'(MW); b++)
                    if (!dq[0].m[b]) mmem[mq[0].idx][8*b +: 8] = dq[0].d[8*b +: 8];
                if (dq[0].m == '0) mknown[mq[0].idx] = 1'b1;
                dq.delete(0);
            end else if (mq[0].op == RD) begin
                expq.push_back(mmem[mq[0].idx]);
                expk.push_back(mknown[mq[0].idx]);
            end
            mq.delete(0);
        end
    endfunction

    function automatic void model_cmd(input logic [2:0] op, input int unsigned addr);
        mcmd_t c;
        c.op  = op;
        c.idx = int'((addr >> 3) % DEPTH);
        mq.push_back(c);
        model_retire();
    endfunction

    function automatic void model_dat(input logic [DW-1:0] d, input logic [MW-1:0] m);
        mdat_t x;
        x.d = d;
        x.m = m;
        dq.push_back(x);
        model_retire();
    endfunction

    function automatic logic [DW-1:0] bdata(input int k);
        return {4{32'(k) * 32'h01010101 + 32'h1000}};
    endfunction

    // ---------------- read-return monitors ----------------
    int            va_cnt = 0, va_last = 0, vb_cnt = 0;
    logic [DW-1:0] last_rd_a = '0;

    always @(negedge clk) begin
        if (rst_a_n && ui_a.app_rd_data_valid) begin
            va_cnt++;
            va_last   = cyc_a;
            last_rd_a = ui_a.app_rd_data;
            check_eq("a_rd_end", ui_a.app_rd_data_end, 1);
            if (expq.size() == 0) begin
                check_eq("a_unexpected_valid", ui_a.app_rd_data_valid, 0);
            end else begin
                logic [DW-1:0] e;
                bit k;
                e = expq.pop_front();
                k = expk.pop_front();
                if (k) check_eq("a_rd_data", ui_a.app_rd_data, e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b_n && ui_b.app_rd_data_valid) begin
            vb_cnt++;
            check_eq("b_rd_end", ui_b.app_rd_data_end, 1);
            if (expb.size() == 0) check_eq("b_unexpected_valid", ui_b.app_rd_data_valid, 0);
            else                  check_eq("b_rd_data", ui_b.app_rd_data, expb.pop_front());
        end
    end

    // ---------------- drivers ----------------
    int acc_cyc = 0;

    task automatic drive(input bit sel, input bit en, input logic [2:0] op, input int unsigned addr,
                         input bit wren, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit e);
        if (!sel) begin
            ui_a.app_en = en; ui_a.app_cmd = op; ui_a.app_addr = AW'(addr);
            ui_a.app_wdf_wren = wren; ui_a.app_wdf_data = d; ui_a.app_wdf_mask = m; ui_a.app_wdf_end = e;
        end else begin
            ui_b.app_en = en; ui_b.app_cmd = op; ui_b.app_addr = AW'(addr);
            ui_b.app_wdf_wren = wren; ui_b.app_wdf_data = d; ui_b.app_wdf_mask = m; ui_b.app_wdf_end = e;
        end
    endtask

    // Present a command and/or a data beat; hold each until accepted (bounded).
    task automatic xfer(input bit sel, input bit do_c, input logic [2:0] op, input int unsigned addr,
                        input bit do_d, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit e);
        bit c_pend = do_c;
        bit d_pend = do_d;
        int guard  = 0;
        drive(sel, c_pend, op, addr, d_pend, d, m, e);
        while ((c_pend || d_pend) && guard < 300) begin
            @(negedge clk);
            if (c_pend && (sel ? ui_b.app_rdy : ui_a.app_rdy)) begin
                c_pend  = 1'b0;
                acc_cyc = sel ? cyc_b : cyc_a;
                if (!sel) model_cmd(op, addr);
            end
            if (d_pend && (sel ? ui_b.app_wdf_rdy : ui_a.app_wdf_rdy)) begin
                d_pend = 1'b0;
                if (!sel) model_dat(d, m);
            end
            @(posedge clk); #1;
            drive(sel, c_pend, op, addr, d_pend, d, m, e);
            guard++;
        end
        check_eq("xfer_accepted", {c_pend, d_pend}, 0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check_eq({tag, "_calib"},   calib_a, 0);
        check_eq({tag, "_rdy"},     ui_a.app_rdy, 0);
        check_eq({tag, "_wdf_rdy"}, ui_a.app_wdf_rdy, 0);
        check_eq({tag, "_valid"},   ui_a.app_rd_data_valid, 0);
        check_eq({tag, "_end"},     ui_a.app_rd_data_end, 0);
        check_eq({tag, "_rd_data"}, ui_a.app_rd_data, 0);
        check_eq({tag, "_err_cmd"}, err_cmd_a, 0);
        check_eq({tag, "_err_wdf"}, err_wdf_a, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        logic [DW-1:0] bpd [6];
        logic [DW-1:0] pend_d[$];
        logic [MW-1:0] pend_m[$];

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        drive(0, 0, WR, 0, 0, '0, '0, 1);
        drive(1, 0, WR, 0, 0, '0, '0, 1);
        wait_cycles(3);
        @(negedge clk);
        check_idle_a("reset");
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // calibration: ready exactly from cycle 64; app_en ignored before that
        ui_a.app_en = 1'b1; ui_a.app_cmd = RD; ui_a.app_addr = '0;
        do begin
            @(negedge clk);
            check_eq("calib_rise", calib_a, cyc_a >= 64);
            check_eq("calib_rdy", ui_a.app_rdy, cyc_a >= 64);
            check_eq("calib_wdf_rdy", ui_a.app_wdf_rdy, cyc_a >= 64);
            if (cyc_a >= 60) ui_a.app_en = 1'b0;
        end while (cyc_a < 70);
        @(posedge clk); #1;
        check_eq("calib_no_early_read", va_cnt, 0);

        // write then read with latency check
        xfer(0, 1, WR, 32'h008, 1, {16{8'hA5}}, '0, 1);
        v0 = va_cnt;
        xfer(0, 1, RD, 32'h008, 0, '0, '0, 1);
        wait_cycles(10);
        check_eq("wr_rd_pulses", va_cnt - v0, 1);
        check_eq("wr_rd_latency", va_last - acc_cyc, 5);
        check_eq("wr_rd_data", last_rd_a, {16{8'hA5}});

        // byte mask and address aliasing
        xfer(0, 1, WR, 32'h10, 1, {DW{1'b1}}, '0, 1);
        xfer(0, 1, WR, 32'h10 + 8 * 1024, 1, '0, 16'hFFFE, 1);
        xfer(0, 1, RD, 32'h10, 0, '0, '0, 1);
        wait_cycles(10);
        check_eq("mask_alias_data", last_rd_a, {{15{8'hFF}}, 8'h00});

        // data lagging commands: command FIFO fills at four
        begin
            int nc = 0, nd = 0, ci = 0;
            for (int k = 0; k < 6; k++) bpd[k] = {$urandom, $urandom, $urandom, $urandom};
            drive(0, 1, WR, 200 * 8, 0, bpd[0], '0, 1);
            while ((nc < 6 || nd < 6) && ci < 100) begin
                @(negedge clk);
                if (ci == 8) check_eq("bp_accepted", nc, 4);
                if (ui_a.app_en && ui_a.app_rdy) begin
                    model_cmd(WR, (200 + nc) * 8);
                    nc++;
                end
                if (ui_a.app_wdf_wren && ui_a.app_wdf_rdy) begin
                    model_dat(bpd[nd], '0);
                    nd++;
                end
                @(posedge clk); #1;
                ci++;
                drive(0, nc < 6, WR, (200 + nc) * 8, (ci >= 11) && (nd < 6), bpd[nd % 6], '0, 1);
            end
            check_eq("bp_cmds", nc, 6);
            check_eq("bp_data", nd, 6);
            for (int k = 0; k < 6; k++) xfer(0, 1, RD, (200 + k) * 8, 0, '0, '0, 1);
            wait_cycles(10);
            check_eq("bp_readback", last_rd_a, bpd[5]);
        end

        // illegal command and missing wdf_end
        v0 = va_cnt;
        check_eq("err_cmd_clear", err_cmd_a, 0);
        xfer(0, 1, 3'b111, 32'h20, 0, '0, '0, 1);
        wait_cycles(8);
        check_eq("err_cmd_set", err_cmd_a, 1);
        check_eq("err_cmd_no_data", va_cnt - v0, 0);
        check_eq("err_wdf_clear", err_wdf_a, 0);
        xfer(0, 0, WR, 0, 1, {4{32'hDEAD_BEEF}}, '0, 0);
        wait_cycles(2);
        check_eq("err_wdf_set", err_wdf_a, 1);

        // reset with four reads in flight
        v0 = va_cnt;
        xfer(0, 1, RD, 32'h008, 0, '0, '0, 1);
        xfer(0, 1, RD, 32'h010, 0, '0, '0, 1);
        xfer(0, 1, RD, 200 * 8, 0, '0, '0, 1);
        xfer(0, 1, RD, 201 * 8, 0, '0, '0, 1);
        rst_a_n = 1'b0;
        mq.delete(); dq.delete(); expq.delete(); expk.delete();
        wait_cycles(2);
        @(negedge clk);
        check_idle_a("midreset");
        @(posedge clk); #1;
        rst_a_n = 1'b1;
        begin
            int g = 0;
            while (!calib_a && g < 200) begin wait_cycles(1); g++; end
        end
        check_eq("reset_no_pulses", va_cnt - v0, 0);
        check_eq("recalib", calib_a, 1);
        xfer(0, 1, RD, 32'h008, 0, '0, '0, 1);
        wait_cycles(10);
        check_eq("mem_retained", last_rd_a, {16{8'hA5}});

        // randomized mix over 16 words with aliasing, masks and lagging data
        for (int k = 0; k < 16; k++)
            xfer(0, 1, WR, (300 + k) * 8, 1, {$urandom, $urandom, $urandom, $urandom}, '0, 1);
        for (int n = 0; n < 200; n++) begin
            int unsigned r, addr;
            logic [DW-1:0] d;
            logic [MW-1:0] m;
            r    = $urandom_range(0, 3);
            addr = (300 + $urandom_range(0, 15) + 1024 * $urandom_range(0, 3)) * 8 + $urandom_range(0, 7);
            d    = {$urandom, $urandom, $urandom, $urandom};
            m    = ($urandom_range(0, 1) != 0) ? MW'($urandom) : '0;
            if (r <= 1) begin
                while (pend_d.size() > 0) xfer(0, 0, WR, 0, 1, pend_d.pop_front(), pend_m.pop_front(), 1);
                xfer(0, 1, RD, addr, 0, '0, '0, 1);
            end else if (r == 2 || pend_d.size() >= 2) begin
                xfer(0, 1, WR, addr, 1, d, m, 1);
            end else begin
                xfer(0, 1, WR, addr, 0, '0, '0, 1);
                pend_d.push_back(d);
                pend_m.push_back(m);
            end
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
        end
        while (pend_d.size() > 0) xfer(0, 0, WR, 0, 1, pend_d.pop_front(), pend_m.pop_front(), 1);
        for (int k = 0; k < 16; k++) xfer(0, 1, RD, (300 + k) * 8, 0, '0, '0, 1);
        wait_cycles(12);
        check_eq("scoreboard_drained", expq.size(), 0);

        // stalling instance: ready low every third cycle, 32 reads return in order
        for (int k = 0; k < 32; k++) xfer(1, 1, WR, k * 8, 1, bdata(k), '0, 1);
        begin
            int k = 0, g = 0;
            drive(1, 1, RD, 0, 0, '0, '0, 1);
            while (k < 32 && g < 200) begin
                @(negedge clk);
                check_eq("stall_rdy", ui_b.app_rdy, (cyc_b % 3) != 0);
                if (ui_b.app_rdy) begin
                    expb.push_back(bdata(k));
                    k++;
                end
                @(posedge clk); #1;
                g++;
                drive(1, k < 32, RD, k * 8, 0, '0, '0, 1);
            end
            check_eq("stall_reads_accepted", k, 32);
        end
        wait_cycles(12);
        check_eq("stall_pulses", vb_cnt, 32);
        check_eq("stall_drained", expb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
